// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one single-beat AXI-Lite
// transaction out, response with data, resp code and saturating bus-cycle latency.
module axil_cmd_master #(
    parameter int unsigned LAT_W = 16
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_resp,
    output logic [LAT_W-1:0] rsp_latency,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [31:0]      m_awaddr,
    output logic             m_wvalid,
    input  logic             m_wready,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    input  logic             m_bvalid,
    output logic             m_bready,
    input  logic [1:0]       m_bresp,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [31:0]      m_araddr,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_rresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_B,
        S_AR,
        S_R,
        S_RSP
    } state_t;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_write_q, rsp_write_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic [1:0]         rsp_resp_q, rsp_resp_d;
    logic [LAT_W-1:0]   lat_q, lat_d, lat_inc;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic [31:0]        awaddr_q, awaddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        araddr_q, araddr_d;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            lat_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            lat_q       <= lat_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
        end
    end

    // Latency counts every cycle spent in a bus state; the final bus cycle is already counted.
    assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        lat_d       = lat_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    rsp_write_d = cmd_write;
                    lat_d       = LAT_W'(1);
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_WR: begin
                lat_d = lat_inc;
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_B;
                end
            end
            S_B: begin
                if (m_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    lat_d = lat_inc;
                end
            end
            S_AR: begin
                lat_d = lat_inc;
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (m_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = m_rresp;
                    rsp_rdata_d = m_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    lat_d = lat_inc;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_latency = lat_q;
    assign m_awvalid   = awvalid_q;
    assign m_awaddr    = awaddr_q;
    assign m_wvalid    = wvalid_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_bready    = bready_q;
    assign m_arvalid   = arvalid_q;
    assign m_araddr    = araddr_q;
    assign m_rready    = rready_q;

endmodule
